pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared states, constants and hazard helper for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load-use hazard: the load in EX writes a register the ID instruction reads; $zero never counts
    function automatic logic is_ldhaz(input logic       load_ex,
                                      input logic [4:0] dst_ex,
                                      input logic [4:0] rs_id,
                                      input logic [4:0] rt_id);
        return load_ex && (dst_ex != REG_ZERO) && ((dst_ex == rs_id) || (dst_ex == rt_id));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline status inputs and stall/flush control outputs
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_RtRd;
    logic             EXMEM_Branch;
    logic             EXMEM_Zero;
    logic             EXMEM_JRegControl;
    logic             EXMEM_MemRead;
    logic             EXMEM_MemWrite;
    logic             Mem_Ready;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Bubble;
    logic             Flush_IFID;
    logic             Flush_IDEX;
    logic             Flush_EXMEM;
    logic             Pipe_Hold;
    logic             PCSrc;
    logic             Mem_Err;
    logic [1:0]       Ctrl_State;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output IFID_Rs, IFID_Rt, IDEX_MemRead, IDEX_RtRd, EXMEM_Branch, EXMEM_Zero,
               EXMEM_JRegControl, EXMEM_MemRead, EXMEM_MemWrite, Mem_Ready,
        input  PC_Write, IFID_Write, IDEX_Bubble, Flush_IFID, Flush_IDEX, Flush_EXMEM,
               Pipe_Hold, PCSrc, Mem_Err, Ctrl_State, StallCount, FlushCount
    );

    modport slave (
        input  IFID_Rs, IFID_Rt, IDEX_MemRead, IDEX_RtRd, EXMEM_Branch, EXMEM_Zero,
               EXMEM_JRegControl, EXMEM_MemRead, EXMEM_MemWrite, Mem_Ready,
        output PC_Write, IFID_Write, IDEX_Bubble, Flush_IFID, Flush_IDEX, Flush_EXMEM,
               Pipe_Hold, PCSrc, Mem_Err, Ctrl_State, StallCount, FlushCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Hold at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Count register; clear has priority over increment
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int            TW         = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    ctrl_state_t state_q, state_d;
    logic        mem_err_q, mem_err_d;
    logic        taken, memwait, ldhaz, ldhaz_en, timeout;
    logic        pc_write, ifid_write, bubble, flush_all, hold, pcsrc;
    logic        stall_inc, flush_inc, timer_run;
    logic [TW-1:0] timer;

    assign taken    = (bus.EXMEM_Branch & bus.EXMEM_Zero) | bus.EXMEM_JRegControl;
    assign memwait  = (bus.EXMEM_MemRead | bus.EXMEM_MemWrite) & ~bus.Mem_Ready;
    assign ldhaz    = is_ldhaz(bus.IDEX_MemRead, bus.IDEX_RtRd, bus.IFID_Rs, bus.IFID_Rt);
    // After a bubble or a flush the ID instruction is either already stalled once or squashed
    assign ldhaz_en = (state_q == ST_RUN) || (state_q == ST_MEMWAIT);
    assign timeout  = (state_q == ST_MEMWAIT) && memwait && (timer == TIMER_LAST);

    // Mealy control decode: memwait > taken > ldhaz > normal; outputs idle while in reset
    always_comb begin
        state_d    = ST_RUN;
        mem_err_d  = mem_err_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;
        flush_all  = 1'b0;
        hold       = 1'b0;
        pcsrc      = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        timer_run  = 1'b0;
        if (Rst) begin
            if (memwait) begin
                hold       = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                stall_inc  = 1'b1;
                state_d    = ST_MEMWAIT;
                if (state_q == ST_MEMWAIT) begin
                    timer_run = 1'b1;
                    if (timeout) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end else if (taken) begin
                pcsrc     = 1'b1;
                flush_all = 1'b1;
                flush_inc = 1'b1;
                state_d   = ST_FLUSH;
            end else if (ldhaz && ldhaz_en) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                bubble     = 1'b1;
                stall_inc  = 1'b1;
                state_d    = ST_LDSTALL;
            end
        end
    end

    // State and sticky timeout flag
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= ST_RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (Clk),
        .clr_n_i (Rst),
        .inc_i   (stall_inc),
        .cnt_o   (bus.StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (Clk),
        .clr_n_i (Rst),
        .inc_i   (flush_inc),
        .cnt_o   (bus.FlushCount)
    );

    // Counts MEMWAIT cycles; zero whenever the controller is not waiting
    sat_counter #(.W(TW)) u_wait_timer (
        .clk     (Clk),
        .clr_n_i (Rst & timer_run & ~timeout),
        .inc_i   (timer_run),
        .cnt_o   (timer)
    );

    assign bus.PC_Write    = pc_write;
    assign bus.IFID_Write  = ifid_write;
    assign bus.IDEX_Bubble = bubble;
    assign bus.Flush_IFID  = flush_all;
    assign bus.Flush_IDEX  = flush_all;
    assign bus.Flush_EXMEM = flush_all;
    assign bus.Pipe_Hold   = hold;
    assign bus.PCSrc       = pcsrc;
    assign bus.Mem_Err     = mem_err_q;
    assign bus.Ctrl_State  = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int CNT_W   = 4;
    localparam int TO      = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [9:0]       ctrl;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] fl;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int m_stall = 0, m_flush = 0, m_waited = 0;
    bit m_err = 0, m_in_wait = 0, m_prev_stall = 0, m_prev_flush = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs and push the model's expected response for that cycle
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ex_mr, input logic [4:0] ex_rd,
                        input logic br, input logic zr, input logic jr,
                        input logic mr, input logic mw, input logic rdy);
        exp_t e;
        logic pcw, ifw, bub, fl, hld, psrc;
        logic [1:0] st;
        bit mwt, tk, lh;
        @(posedge clk);
        #1;
        rst_n                 = rst;
        bus.IFID_Rs           = rs;
        bus.IFID_Rt           = rt;
        bus.IDEX_MemRead      = ex_mr;
        bus.IDEX_RtRd         = ex_rd;
        bus.EXMEM_Branch      = br;
        bus.EXMEM_Zero        = zr;
        bus.EXMEM_JRegControl = jr;
        bus.EXMEM_MemRead     = mr;
        bus.EXMEM_MemWrite    = mw;
        bus.Mem_Ready         = rdy;

        st = m_in_wait ? 2'd3 : m_prev_flush ? 2'd2 : m_prev_stall ? 2'd1 : 2'd0;
        e.st  = m_stall[CNT_W-1:0];
        e.fl  = m_flush[CNT_W-1:0];
        e.err = m_err;
        pcw = 1; ifw = 1; bub = 0; fl = 0; hld = 0; psrc = 0;

        if (!rst) begin
            m_stall = 0; m_flush = 0; m_waited = 0;
            m_err = 0; m_in_wait = 0; m_prev_stall = 0; m_prev_flush = 0;
        end else begin
            mwt = (mr || mw) && !rdy;
            tk  = (br && zr) || jr;
            lh  = ex_mr && ex_rd != 0 && (ex_rd == rs || ex_rd == rt)
                  && !m_prev_stall && !m_prev_flush;
            m_prev_stall = 0;
            m_prev_flush = 0;
            if (mwt) begin
                hld = 1; pcw = 0; ifw = 0;
                if (m_stall < CNT_MAX) m_stall++;
                if (m_in_wait) begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_err = 1; m_in_wait = 0; m_waited = 0;
                    end
                end else begin
                    m_in_wait = 1; m_waited = 0;
                end
            end else begin
                m_in_wait = 0; m_waited = 0;
                if (tk) begin
                    psrc = 1; fl = 1; m_prev_flush = 1;
                    if (m_flush < CNT_MAX) m_flush++;
                end else if (lh) begin
                    pcw = 0; ifw = 0; bub = 1; m_prev_stall = 1;
                    if (m_stall < CNT_MAX) m_stall++;
                end
            end
        end
        e.ctrl = {pcw, ifw, bub, fl, fl, fl, hld, psrc, st};
        sb.push_back(e);
    endtask

    // Monitor: every cycle with a pending expectation, compare mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctrl{pcw,ifw,bub,fifid,fidex,fexmem,hold,pcsrc,state}",
                  32'({bus.PC_Write, bus.IFID_Write, bus.IDEX_Bubble, bus.Flush_IFID,
                       bus.Flush_IDEX, bus.Flush_EXMEM, bus.Pipe_Hold, bus.PCSrc,
                       bus.Ctrl_State}), 32'(e.ctrl));
            check("StallCount", 32'(bus.StallCount), 32'(e.st));
            check("FlushCount", 32'(bus.FlushCount), 32'(e.fl));
            check("Mem_Err", 32'(bus.Mem_Err), 32'(e.err));
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.IFID_Rs = '0; bus.IFID_Rt = '0; bus.IDEX_MemRead = 0; bus.IDEX_RtRd = '0;
        bus.EXMEM_Branch = 0; bus.EXMEM_Zero = 0; bus.EXMEM_JRegControl = 0;
        bus.EXMEM_MemRead = 0; bus.EXMEM_MemWrite = 0; bus.Mem_Ready = 1;
        repeat (2) @(posedge clk);

        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // load-use on Rs, then same hazard visible during LDSTALL is ignored
        step(1, 2, 5, 1, 2, 0, 0, 0, 0, 0, 1);
        step(1, 2, 5, 1, 2, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // taken beq, then JR
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        // taken + ldhaz together: flush only
        step(1, 7, 3, 1, 3, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // store waits 3 cycles then completes
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // memory never ready: timeout, sticky error
        repeat (7) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // reset in the middle of a wait, then a $zero load never stalls
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // randomized traffic over a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 5));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
